dual_issue_scheduler: RTL and testbench

Issue-stage scheduler for the dual-pipeline MIPS core. Each cycle it takes the two oldest instructions from the instruction queue, already pre-decoded per slot into class flags and register fields, and decides whether to issue zero, one or two. It serialises privileged/trap instructions, keeps each branch and its delay slot ordered, blocks HI/LO accesses while the multi-cycle divider is running, and tells the queue how many entries to pop.

---
 rtl/dual_issue_scheduler.sv | 127 ++++++++++++
 tb/tb_dual_issue_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dual_issue_scheduler
// Purpose  : Issue-stage scheduler choosing zero, one or two instructions per
//            cycle. Define DUAL_ISSUE_EN to enable slot-1 issue.
// Revision : 1.0  initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       ex_ready,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       is_branch0,
    input  logic       is_branch1,
    input  logic       is_trap_priv0,
    input  logic       is_trap_priv1,
    input  logic       is_hilo0,
    input  logic       is_hilo1,
    input  logic       is_div0,
    input  logic       is_div1,
    input  logic       is_mem0,
    input  logic       is_mem1,
    input  logic [4:0] dst0,
    input  logic       dst0_we,
    input  logic [4:0] rs1,
    input  logic [4:0] rt1,
    input  logic       rs1_rd,
    input  logic       rt1_rd,
    output logic       issue0,
    output logic       issue1,
    output logic [1:0] pop_cnt,
    output logic       is_delay_slot0,
    output logic       div_busy
);

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        WAIT_DS = 1'b1
    } state_t;

    localparam logic [5:0] c_div_load = 6'(DIV_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_div_cnt;
    logic [5:0] w_div_cnt_nxt;
    logic       w_issue0;
    logic       w_issue1;
    logic       w_div_busy;
    logic       w_div_start;

    assign w_div_busy = (r_div_cnt != 6'd0);
    assign w_issue0   = !(!valid0 || !ex_ready || flush || (is_hilo0 && w_div_busy));

`ifdef DUAL_ISSUE_EN
    logic w_raw;

    assign w_raw = dst0_we && (dst0 != 5'd0) &&
                   ((rs1_rd && (rs1 == dst0)) || (rt1_rd && (rt1 == dst0)));

    // A branch in slot 1 would leave its delay slot behind, so it never pairs.
    assign w_issue1 = w_issue0 && valid1 && (r_state == NORMAL) &&
                      !is_branch1 &&
                      !is_trap_priv0 && !is_trap_priv1 &&
                      !(is_hilo0 && is_hilo1) &&
                      !(is_hilo1 && w_div_busy) &&
                      !(is_mem0 && is_mem1) &&
                      !w_raw;

    assign w_div_start = (w_issue0 && is_div0) || (w_issue1 && is_div1);
`else
    logic w_unused;

    assign w_unused = ^{valid1, is_branch1, is_trap_priv0, is_trap_priv1,
                        is_hilo1, is_div1, is_mem0, is_mem1, dst0, dst0_we,
                        rs1, rt1, rs1_rd, rt1_rd};

    assign w_issue1    = 1'b0;
    assign w_div_start = w_issue0 && is_div0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = NORMAL;
        end else begin
            case (r_state)
                NORMAL:  if (w_issue0 && is_branch0 && !w_issue1) w_state_nxt = WAIT_DS;
                WAIT_DS: if (w_issue0) w_state_nxt = NORMAL;
                default: w_state_nxt = NORMAL;
            endcase
        end
    end

    // Counter is deliberately untouched by flush: an issued divide completes.
    always_comb begin
        w_div_cnt_nxt = r_div_cnt;
        if (w_div_start) begin
            w_div_cnt_nxt = c_div_load;
        end else if (w_div_busy) begin
            w_div_cnt_nxt = r_div_cnt - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= NORMAL;
            r_div_cnt <= 6'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    assign issue0         = w_issue0;
    assign issue1         = w_issue1;
    assign pop_cnt        = {1'b0, w_issue0} + {1'b0, w_issue1};
    assign is_delay_slot0 = (r_state == WAIT_DS) && w_issue0;
    assign div_busy       = w_div_busy;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dual_issue_scheduler
// Purpose  : Directed self-checking bench for dual_issue_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_dual_issue_scheduler;

`ifdef DUAL_ISSUE_EN
    localparam int DUAL = 1;
`else
    localparam int DUAL = 0;
`endif
    localparam int DIVC = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, ex_ready;
    logic       valid0, valid1;
    logic       is_branch0, is_branch1, is_trap_priv0, is_trap_priv1;
    logic       is_hilo0, is_hilo1, is_div0, is_div1, is_mem0, is_mem1;
    logic [4:0] dst0, rs1, rt1;
    logic       dst0_we, rs1_rd, rt1_rd;
    logic       issue0, issue1, is_delay_slot0, div_busy;
    logic [1:0] pop_cnt;

    int n_pass  = 0;
    int n_total = 0;

    dual_issue_scheduler #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_ready(ex_ready),
        .valid0(valid0), .valid1(valid1),
        .is_branch0(is_branch0), .is_branch1(is_branch1),
        .is_trap_priv0(is_trap_priv0), .is_trap_priv1(is_trap_priv1),
        .is_hilo0(is_hilo0), .is_hilo1(is_hilo1),
        .is_div0(is_div0), .is_div1(is_div1),
        .is_mem0(is_mem0), .is_mem1(is_mem1),
        .dst0(dst0), .dst0_we(dst0_we),
        .rs1(rs1), .rt1(rt1), .rs1_rd(rs1_rd), .rt1_rd(rt1_rd),
        .issue0(issue0), .issue1(issue1), .pop_cnt(pop_cnt),
        .is_delay_slot0(is_delay_slot0), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clr();
        flush = 0; ex_ready = 1; valid0 = 0; valid1 = 0;
        is_branch0 = 0; is_branch1 = 0; is_trap_priv0 = 0; is_trap_priv1 = 0;
        is_hilo0 = 0; is_hilo1 = 0; is_div0 = 0; is_div1 = 0;
        is_mem0 = 0; is_mem1 = 0;
        dst0 = 5'd0; dst0_we = 0; rs1 = 5'd0; rt1 = 5'd0; rs1_rd = 0; rt1_rd = 0;
    endtask

    // ADDU r3,r1,r2 in slot 0 and ADDU r4,r5,r6 in slot 1
    task automatic addu_pair();
        clr();
        valid0 = 1; valid1 = 1; dst0 = 5'd3; dst0_we = 1;
        rs1 = 5'd5; rt1 = 5'd6; rs1_rd = 1; rt1_rd = 1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst = 1;
        #1;
        chk("rst_div_busy", div_busy, 0);
        chk("rst_ds0", is_delay_slot0, 0);
        chk("rst_pop_idle", pop_cnt, 0);
        chk("rst_issue0_idle", issue0, 0);
        step(); step();
        rst = 0;

        // Independent pair
        step(); addu_pair(); #1;
        chk("pair_issue0", issue0, 1);
        chk("pair_issue1", issue1, DUAL);
        chk("pair_pop", pop_cnt, 1 + DUAL);
        step(); addu_pair(); #1;
        chk("pair_again_ds0", is_delay_slot0, 0);
        chk("pair_again_pop", pop_cnt, 1 + DUAL);

        // RAW on r3, then same sources with dst0=r0
        step(); addu_pair(); rs1 = 5'd3; rt1 = 5'd1; #1;
        chk("raw_issue1", issue1, 0);
        chk("raw_pop", pop_cnt, 1);
        step(); addu_pair(); rs1 = 5'd1; rt1 = 5'd3; #1;
        chk("raw_rt_pop", pop_cnt, 1);
        step(); addu_pair(); dst0 = 5'd0; rs1 = 5'd0; rt1 = 5'd0; #1;
        chk("raw_r0_pop", pop_cnt, 1 + DUAL);
        step(); addu_pair(); rs1 = 5'd3; rs1_rd = 0; rt1_rd = 0; #1;
        chk("raw_noread_pop", pop_cnt, 1 + DUAL);

        // BEQ alone -> WAIT_DS, stall once, then delay slot
        step(); clr(); valid0 = 1; is_branch0 = 1; #1;
        chk("beq_pop", pop_cnt, 1);
        chk("beq_ds0", is_delay_slot0, 0);
        step(); addu_pair(); ex_ready = 0; #1;
        chk("ds_stall_pop", pop_cnt, 0);
        chk("ds_stall_ds0", is_delay_slot0, 0);
        step(); addu_pair(); #1;
        chk("ds_issue0", issue0, 1);
        chk("ds_flag", is_delay_slot0, 1);
        chk("ds_issue1", issue1, 0);
        step(); addu_pair(); #1;
        chk("after_ds_flag", is_delay_slot0, 0);
        chk("after_ds_pop", pop_cnt, 1 + DUAL);

        // Branch paired with its delay slot stays NORMAL only when dual-issuing
        step(); addu_pair(); is_branch0 = 1; dst0_we = 0; #1;
        chk("br_pair_pop", pop_cnt, 1 + DUAL);
        step(); addu_pair(); #1;
        chk("br_pair_next_ds0", is_delay_slot0, 1 - DUAL);
        chk("br_pair_next_pop", pop_cnt, DUAL ? 2 : 1);
        step(); addu_pair(); is_branch1 = 1; #1;
        chk("br_slot1_pop", pop_cnt, 1);

        // Trap / port conflicts
        step(); addu_pair(); is_trap_priv1 = 1; #1;
        chk("mtc0_s1_pop", pop_cnt, 1);
        step(); addu_pair(); is_trap_priv0 = 1; dst0_we = 0; #1;
        chk("mtc0_s0_pop", pop_cnt, 1);
        step(); addu_pair(); is_mem0 = 1; is_mem1 = 1; #1;
        chk("mem_mem_pop", pop_cnt, 1);
        step(); addu_pair(); is_mem1 = 1; #1;
        chk("alu_mem_pop", pop_cnt, 1 + DUAL);
        step(); addu_pair(); is_hilo0 = 1; is_hilo1 = 1; #1;
        chk("hilo_hilo_pop", pop_cnt, 1);

        // DIV in slot 1 loads the counter only when slot 1 issues
        step(); addu_pair(); is_div1 = 1; is_hilo1 = 1; #1;
        chk("div_s1_pop", pop_cnt, 1 + DUAL);
        step(); clr(); #1;
        chk("div_s1_busy", div_busy, DUAL);
        for (int i = 0; i < DIVC; i++) step();
        #1;
        chk("div_s1_done", div_busy, 0);

        // DIV at cycle 0, MFLO waits at head for DIV_CYCLES cycles
        step(); clr(); valid0 = 1; is_hilo0 = 1; is_div0 = 1; #1;
        chk("div_pop", pop_cnt, 1);
        chk("div_busy_c0", div_busy, 0);
        for (int c = 1; c <= DIVC; c++) begin
            step(); clr(); valid0 = 1; is_hilo0 = 1; #1;
            chk($sformatf("mflo_blocked_c%0d", c), pop_cnt, 0);
            if (c == 1 || c == DIVC) chk($sformatf("busy_c%0d", c), div_busy, 1);
        end
        step(); clr(); valid0 = 1; is_hilo0 = 1; #1;
        chk("mflo_issue_c34", issue0, 1);
        chk("busy_c34", div_busy, 0);

        // Divide busy: MFHI in slot 1 is held back, then WAIT_DS, then async reset
        step(); clr(); valid0 = 1; is_hilo0 = 1; is_div0 = 1; #1;
        step(); addu_pair(); is_hilo1 = 1; #1;
        chk("busy_hilo1_pop", pop_cnt, 1);
        step(); clr(); valid0 = 1; is_branch0 = 1; #1;
        chk("busy_beq_pop", pop_cnt, 1);
        for (int i = 0; i < 11; i++) begin
            step(); clr();
        end
        step(); addu_pair(); ex_ready = 0; #1;
        chk("pre_rst_busy", div_busy, 1);
        #2 rst = 1; #1;
        chk("rst_async_busy", div_busy, 0);
        ex_ready = 1; #1;
        chk("rst_async_ds0", is_delay_slot0, 0);
        chk("rst_issue0_follows", issue0, 1);
        step(); rst = 0;

        // Flush in WAIT_DS returns to NORMAL
        step(); clr(); valid0 = 1; is_branch0 = 1; #1;
        step(); addu_pair(); flush = 1; ex_ready = 0; #1;
        chk("flush_pop", pop_cnt, 0);
        chk("flush_issue0", issue0, 0);
        step(); addu_pair(); #1;
        chk("after_flush_ds0", is_delay_slot0, 0);
        chk("after_flush_pop", pop_cnt, 1 + DUAL);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
